// File: rtl/button_input_conditioner_if.sv
// Button bus between the board pins and the input conditioner.
// The board side (master) drives the raw pins and observes the conditioned
// level, edge pulses and toggle latch; the conditioner (slave) does the reverse.
interface button_input_conditioner_if #(
  parameter int N_BTN = 4
) ();

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_rise;
  logic [N_BTN-1:0] btn_fall;
  logic [N_BTN-1:0] btn_toggle;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_rise,
    input  btn_fall,
    input  btn_toggle
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_rise,
    output btn_fall,
    output btn_toggle
  );

endinterface

// File: rtl/button_input_conditioner.sv
// Push-button input conditioner.
// Each channel: SYNC_STAGES-deep synchronizer, four-state debounce machine,
// registered one-cycle rise/fall pulses and a toggle latch that flips on every
// accepted press. Channels share only the clock and reset.
// Optional feature: define BTN_AUTOREPEAT_EN to add hold-to-repeat rise pulses
// (first after REPEAT_DELAY cycles held, then every REPEAT_PERIOD cycles).
// Without the macro no repeat logic exists and each press yields one rise pulse.
module button_input_conditioner #(
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic                      input_clock1_clk_1,
  input  logic                      input_reset_rst_0,
  button_input_conditioner_if.slave btn
);

  // Debounce counter only ever needs to hold 0..DEBOUNCE_CYCLES.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'sd1);
  // With a one-cycle debounce window a change is accepted straight from STABLE.
  localparam bit FAST_ACCEPT = (DEBOUNCE_CYCLES == 32'sd1);

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 32'sd1);
  localparam logic [REP_W-1:0] REP_ZERO        = REP_W'(0);
  localparam logic [REP_W-1:0] REP_ONE         = REP_W'(1);
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 32'sd1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 32'sd1);
`endif

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    CHECK_HIGH  = 2'b01,
    STABLE_HIGH = 2'b10,
    CHECK_LOW   = 2'b11
  } deb_state_e;

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < 32'sd2 || SYNC_STAGES > 32'sd4) begin : g_bad_sync
    $error("button_input_conditioner: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 32'sd1) begin : g_bad_debounce
    $error("button_input_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 32'sd1 || REPEAT_PERIOD < 32'sd1) begin : g_bad_repeat
    $error("button_input_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  // sync_r[0] is the only flop that samples the asynchronous pins.
  logic [SYNC_STAGES-1:0][N_BTN-1:0] sync_r;

  // Synchronizer shift chain for all channels.
  always_ff @(posedge input_clock1_clk_1) begin
    if (input_reset_rst_0) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn.btn_raw};
    end
  end

  for (genvar c = 0; c < N_BTN; c++) begin : g_chan
    deb_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             rise_req_r;
    logic             fall_req_r;
    logic             rise_r;
    logic             fall_r;
    logic             toggle_r;
    logic             s_s;
    logic             rep_pulse_s;

    assign s_s = sync_r[SYNC_STAGES-1][c];

`ifdef BTN_AUTOREPEAT_EN
    logic [REP_W-1:0] rep_cnt_r;
    logic             rep_first_r;
    logic             rep_req_r;
    logic [REP_W-1:0] rep_last_s;

    assign rep_last_s  = rep_first_r ? REP_DELAY_LAST : REP_PERIOD_LAST;
    assign rep_pulse_s = rep_req_r;

    // Hold timer: runs in STABLE_HIGH, freezes during CHECK_LOW so a release
    // bounce does not restart the cadence, clears in every other state.
    always_ff @(posedge input_clock1_clk_1) begin
      if (input_reset_rst_0) begin
        rep_cnt_r   <= REP_ZERO;
        rep_first_r <= 1'b1;
        rep_req_r   <= 1'b0;
      end else begin
        rep_req_r <= 1'b0;
        case (state_r)
          STABLE_HIGH: begin
            if (rep_cnt_r >= rep_last_s) begin
              rep_req_r   <= 1'b1;
              rep_cnt_r   <= REP_ZERO;
              rep_first_r <= 1'b0;
            end else begin
              rep_cnt_r <= rep_cnt_r + REP_ONE;
            end
          end
          CHECK_LOW: begin
            rep_cnt_r <= rep_cnt_r;
          end
          default: begin
            rep_cnt_r   <= REP_ZERO;
            rep_first_r <= 1'b1;
          end
        endcase
      end
    end
`else
    assign rep_pulse_s = 1'b0;
`endif

    // Debounce state machine with registered level, edge pulses and toggle.
    // An accept sets a request flag together with the new level; the pulse
    // itself is emitted one cycle later so it follows the level update.
    always_ff @(posedge input_clock1_clk_1) begin
      if (input_reset_rst_0) begin
        state_r    <= STABLE_LOW;
        cnt_r      <= CNT_ZERO;
        level_r    <= 1'b0;
        rise_req_r <= 1'b0;
        fall_req_r <= 1'b0;
        rise_r     <= 1'b0;
        fall_r     <= 1'b0;
        toggle_r   <= 1'b0;
      end else begin
        rise_r     <= rise_req_r | rep_pulse_s;
        fall_r     <= fall_req_r;
        toggle_r   <= toggle_r ^ rise_req_r;
        rise_req_r <= 1'b0;
        fall_req_r <= 1'b0;
        case (state_r)
          STABLE_LOW: begin
            if (s_s) begin
              if (FAST_ACCEPT) begin
                state_r    <= STABLE_HIGH;
                level_r    <= 1'b1;
                rise_req_r <= 1'b1;
                cnt_r      <= CNT_ZERO;
              end else begin
                state_r <= CHECK_HIGH;
                cnt_r   <= CNT_ONE;
              end
            end else begin
              cnt_r <= CNT_ZERO;
            end
          end
          CHECK_HIGH: begin
            if (s_s) begin
              if (cnt_r >= CNT_LAST) begin
                state_r    <= STABLE_HIGH;
                level_r    <= 1'b1;
                rise_req_r <= 1'b1;
                cnt_r      <= CNT_ZERO;
              end else begin
                cnt_r <= cnt_r + CNT_ONE;
              end
            end else begin
              state_r <= STABLE_LOW;
              cnt_r   <= CNT_ZERO;
            end
          end
          STABLE_HIGH: begin
            if (!s_s) begin
              if (FAST_ACCEPT) begin
                state_r    <= STABLE_LOW;
                level_r    <= 1'b0;
                fall_req_r <= 1'b1;
                cnt_r      <= CNT_ZERO;
              end else begin
                state_r <= CHECK_LOW;
                cnt_r   <= CNT_ONE;
              end
            end else begin
              cnt_r <= CNT_ZERO;
            end
          end
          CHECK_LOW: begin
            if (!s_s) begin
              if (cnt_r >= CNT_LAST) begin
                state_r    <= STABLE_LOW;
                level_r    <= 1'b0;
                fall_req_r <= 1'b1;
                cnt_r      <= CNT_ZERO;
              end else begin
                cnt_r <= cnt_r + CNT_ONE;
              end
            end else begin
              state_r <= STABLE_HIGH;
              cnt_r   <= CNT_ZERO;
            end
          end
          default: begin
            state_r <= STABLE_LOW;
            level_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
          end
        endcase
      end
    end

    assign btn.btn_level[c]  = level_r;
    assign btn.btn_rise[c]   = rise_r;
    assign btn.btn_fall[c]   = fall_r;
    assign btn.btn_toggle[c] = toggle_r;
  end

endmodule

// File: tb/tb_button_input_conditioner.sv
// Self-checking bench for button_input_conditioner: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model that
// accepts a new level once the synchronized input has disagreed with the
// current level for DEBOUNCE_CYCLES consecutive samples.
module tb_button_input_conditioner;

  localparam int N       = 4;
  localparam int SYNC    = 2;
  localparam int DEB     = 16;
  localparam int RDELAY  = 64;
  localparam int RPERIOD = 16;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_input_conditioner_if #(.N_BTN(N)) bus ();

  button_input_conditioner #(
    .N_BTN(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPERIOD)
  ) dut (
    .input_clock1_clk_1(clk),
    .input_reset_rst_0(rst),
    .btn(bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [N-1:0] m_level  = '0;
  logic [N-1:0] m_rise   = '0;
  logic [N-1:0] m_fall   = '0;
  logic [N-1:0] m_toggle = '0;
  logic [N-1:0] p_rise   = '0;
  logic [N-1:0] p_fall   = '0;
  logic [N-1:0] p_rep    = '0;
  int           runlen[N];
  int           held[N];
  logic [N-1:0] raw_pipe[$];

  task automatic model_edge();
    logic [N-1:0] s;
    if (rst) begin
      m_level = '0; m_rise = '0; m_fall = '0; m_toggle = '0;
      p_rise = '0; p_fall = '0; p_rep = '0;
      raw_pipe.delete();
      for (int i = 0; i < SYNC; i++) raw_pipe.push_back('0);
      for (int c = 0; c < N; c++) begin
        runlen[c] = 0;
        held[c]   = 0;
      end
    end else begin
      s = raw_pipe.pop_front();
      raw_pipe.push_back(bus.btn_raw);
      m_rise   = p_rise | p_rep;
      m_fall   = p_fall;
      m_toggle = m_toggle ^ p_rise;
      p_rise = '0; p_fall = '0; p_rep = '0;
      for (int c = 0; c < N; c++) begin
        if (AR && m_level[c] && runlen[c] == 0) begin
          held[c]++;
          if (held[c] >= RDELAY && ((held[c] - RDELAY) % RPERIOD) == 0) p_rep[c] = 1'b1;
        end
        if (s[c] != m_level[c]) runlen[c]++;
        else runlen[c] = 0;
        if (runlen[c] >= DEB) begin
          m_level[c] = s[c];
          runlen[c]  = 0;
          held[c]    = 0;
          if (s[c]) p_rise[c] = 1'b1;
          else p_fall[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [4*N-1:0] dut_outs();
    return {bus.btn_level, bus.btn_rise, bus.btn_fall, bus.btn_toggle};
  endfunction

  function automatic logic [4*N-1:0] model_outs();
    return {m_level, m_rise, m_fall, m_toggle};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.btn_raw = 4'($urandom);
    for (int k = 0; k < 3; k++) tick();
    total++;
    if (dut_outs() !== 16'h0000) begin
      bad++; $display("FAIL reset_outputs got=%h want=%h", dut_outs(), 16'h0000);
    end
    rst = 1'b0;
    bus.btn_raw = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (dut_outs() !== model_outs()) begin
        bad++; $display("FAIL reset_idle got=%h want=%h", dut_outs(), model_outs());
      end
    end
  endtask

  task automatic test_clean_press();
    int rises = 0;
    bus.btn_raw[0] = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (bus.btn_rise[0]) rises++;
      total++;
      if (dut_outs() !== model_outs()) begin
        bad++; $display("FAIL clean_model e=%0d got=%h want=%h", e, dut_outs(), model_outs());
      end
      if (e == 17) begin
        total++;
        if (bus.btn_level[0] !== 1'b0) begin
          bad++; $display("FAIL clean_early_level got=%b want=0", bus.btn_level[0]);
        end
      end
      if (e == 18) begin
        total++;
        if (bus.btn_level[0] !== 1'b1) begin
          bad++; $display("FAIL clean_level_edge18 got=%b want=1", bus.btn_level[0]);
        end
      end
      if (e == 19) begin
        total++;
        if (bus.btn_rise[0] !== 1'b1) begin
          bad++; $display("FAIL clean_rise_edge19 got=%b want=1", bus.btn_rise[0]);
        end
      end
    end
    total++;
    if (rises != 1) begin
      bad++; $display("FAIL clean_rise_count got=%0d want=1", rises);
    end
    total++;
    if (bus.btn_toggle[0] !== 1'b1) begin
      bad++; $display("FAIL clean_toggle got=%b want=1", bus.btn_toggle[0]);
    end
    bus.btn_raw[0] = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      tick();
      total++;
      if (dut_outs() !== model_outs()) begin
        bad++; $display("FAIL clean_release e=%0d got=%h want=%h", e, dut_outs(), model_outs());
      end
    end
  endtask

  task automatic test_bounce();
    int early_rises = 0;
    for (int e = 1; e <= 50; e++) begin
      if (e <= 12) bus.btn_raw[1] = (((e - 1) / 3) % 2) == 0;
      else bus.btn_raw[1] = 1'b1;
      tick();
      if (e < 31 && bus.btn_rise[1]) early_rises++;
      total++;
      if (dut_outs() !== model_outs()) begin
        bad++; $display("FAIL bounce_model e=%0d got=%h want=%h", e, dut_outs(), model_outs());
      end
      if (e == 29 || e == 30) begin
        total++;
        if (bus.btn_level[1] !== (e == 30)) begin
          bad++; $display("FAIL bounce_level e=%0d got=%b want=%b", e, bus.btn_level[1], (e == 30));
        end
      end
    end
    total++;
    if (early_rises != 0) begin
      bad++; $display("FAIL bounce_no_pulse got=%0d want=0", early_rises);
    end
    bus.btn_raw[1] = 1'b0;
    for (int e = 1; e <= 25; e++) tick();
  endtask

  task automatic test_glitch();
    int rises = 0;
    int highs = 0;
    for (int e = 1; e <= 45; e++) begin
      bus.btn_raw[2] = (e <= 15);
      tick();
      if (bus.btn_rise[2]) rises++;
      if (bus.btn_level[2]) highs++;
      total++;
      if (dut_outs() !== model_outs()) begin
        bad++; $display("FAIL glitch_model e=%0d got=%h want=%h", e, dut_outs(), model_outs());
      end
    end
    total++;
    if (rises != 0 || highs != 0) begin
      bad++; $display("FAIL glitch_reject rises=%0d highs=%0d want 0/0", rises, highs);
    end
  endtask

  task automatic test_reset_mid();
    bus.btn_raw[3] = 1'b1;
    for (int e = 1; e <= 9; e++) tick();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (dut_outs() !== 16'h0000) begin
      bad++; $display("FAIL midreset_outputs got=%h want=%h", dut_outs(), 16'h0000);
    end
    rst = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      total++;
      if (dut_outs() !== model_outs()) begin
        bad++; $display("FAIL midreset_model e=%0d got=%h want=%h", e, dut_outs(), model_outs());
      end
      if (e == 17 || e == 18) begin
        total++;
        if (bus.btn_level[3] !== (e == 18)) begin
          bad++; $display("FAIL midreset_level e=%0d got=%b want=%b", e, bus.btn_level[3], (e == 18));
        end
      end
    end
    bus.btn_raw[3] = 1'b0;
    for (int e = 1; e <= 25; e++) tick();
  endtask

  task automatic test_multi_channel();
    rst = 1'b1;
    bus.btn_raw = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      bus.btn_raw = 4'hF;
      for (int e = 1; e <= 30; e++) begin
        tick();
        total++;
        if (dut_outs() !== model_outs()) begin
          bad++; $display("FAIL multi_model e=%0d got=%h want=%h", e, dut_outs(), model_outs());
        end
        if (e == 19) begin
          total++;
          if (bus.btn_rise !== 4'hF) begin
            bad++; $display("FAIL multi_rise_together got=%b want=1111", bus.btn_rise);
          end
        end
      end
      bus.btn_raw = 4'h0;
      for (int e = 1; e <= 30; e++) tick();
    end
    total++;
    if (bus.btn_toggle !== 4'b0000) begin
      bad++; $display("FAIL multi_toggle got=%b want=0000", bus.btn_toggle);
    end
  endtask

  task automatic test_long_hold();
    int rises = 0;
    int first = -1;
    int second = -1;
`ifdef BTN_AUTOREPEAT_EN
    int want_rises = 9;
`else
    int want_rises = 1;
`endif
    for (int e = 1; e <= 240; e++) begin
      bus.btn_raw[0] = (e <= 200);
      tick();
      if (bus.btn_rise[0]) begin
        rises++;
        if (first < 0) first = e;
        else if (second < 0) second = e;
      end
      total++;
      if (dut_outs() !== model_outs()) begin
        bad++; $display("FAIL hold_model e=%0d got=%h want=%h", e, dut_outs(), model_outs());
      end
    end
    total++;
    if (rises != want_rises) begin
      bad++; $display("FAIL hold_rise_count got=%0d want=%0d", rises, want_rises);
    end
    total++;
    if (first != 19) begin
      bad++; $display("FAIL hold_first_rise got=%0d want=19", first);
    end
`ifdef BTN_AUTOREPEAT_EN
    total++;
    if (second - first != RDELAY) begin
      bad++; $display("FAIL hold_repeat_delay got=%0d want=%0d", second - first, RDELAY);
    end
`endif
    total++;
    if (bus.btn_toggle[0] !== 1'b1) begin
      bad++; $display("FAIL hold_toggle_once got=%b want=1", bus.btn_toggle[0]);
    end
  endtask

  task automatic test_random();
    int left[N];
    for (int c = 0; c < N; c++) left[c] = 1;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++) begin
        left[c]--;
        if (left[c] <= 0) begin
          bus.btn_raw[c] = ~bus.btn_raw[c];
          if ($urandom_range(0, 3) == 0) left[c] = $urandom_range(1, 8);
          else left[c] = $urandom_range(10, 90);
        end
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
      total++;
      if (dut_outs() !== model_outs()) begin
        bad++; $display("FAIL random_model k=%0d got=%h want=%h", k, dut_outs(), model_outs());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.btn_raw = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_reset_mid();
    test_multi_channel();
    test_long_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
